// File: rtl/alu_mdu.sv
// Multi-cycle EX-stage ALU with iterative multiply/divide.
// Single-cycle ops finish in one cycle; mul/div run one bit per cycle.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_NOR   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_MULH  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_MULHU = OP_W'(13);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(14);
  localparam logic [OP_W-1:0] OP_MOD   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_MODU  = OP_W'(17);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] c, hi, lo, md, ar;
  logic [WIDTH-1:0] hi_n, lo_n, alu_res, md_res;
  logic [WIDTH-1:0] ma, mb, r_low;
  logic [WIDTH:0]   sum, r;
  logic [CW-1:0]    cnt;
  logic [OP_W-1:0]  opr;
  logic [SH_W-1:0]  sh;
  logic             neg_q, neg_r, dz;
  logic             accept, is_mul, is_div, is_md, sgn, sa, sb, ge;
  logic             opr_mul;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign C         = c;
  assign accept    = in_valid && in_ready && !flush;

  assign is_mul = (alu_op >= OP_MUL) && (alu_op <= OP_MULHU);
  assign is_div = (alu_op >= OP_DIV) && (alu_op <= OP_MODU);
  assign is_md  = is_mul || is_div;
  assign sgn    = (alu_op == OP_MULH) || (alu_op == OP_DIV) ||
                  (alu_op == OP_MOD);
  assign sa     = sgn && A[WIDTH-1];
  assign sb     = sgn && B[WIDTH-1];
  assign ma     = sa ? -A : A;
  assign mb     = sb ? -B : B;
  assign sh     = B[SH_W-1:0];

  assign opr_mul = (opr >= OP_MUL) && (opr <= OP_MULHU);

  // single-cycle result from the live operands at acceptance
  always_comb begin
    alu_res = A + B;
    unique case (alu_op)
      OP_SUB:  alu_res = A - B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      OP_SLL:  alu_res = A << sh;
      OP_SRL:  alu_res = A >> sh;
      OP_SRA:  alu_res = $signed(A) >>> sh;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, A < B};
      default: alu_res = A + B;
    endcase
  end

  // one shift-add or restoring-subtract step, then sign fix-up
  always_comb begin
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, md} : '0);
    r     = {hi, lo[WIDTH-1]};
    ge    = (r >= {1'b0, md});
    r_low = r[WIDTH-1:0];
    hi_n  = ge ? (r_low - md) : r_low;
    lo_n  = {lo[WIDTH-2:0], ge};
    if (opr_mul) begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo[WIDTH-1:1]};
    end
    md_res = '0;
    unique case (opr)
      OP_MUL:            md_res = lo_n;
      OP_MULH, OP_MULHU: md_res = neg_q ? ~hi_n + WIDTH'(lo_n == '0)
                                        : hi_n;
      OP_DIV, OP_DIVU:   md_res = dz ? '1 : (neg_q ? -lo_n : lo_n);
      default:           md_res = dz ? ar : (neg_r ? -hi_n : hi_n);
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next-state logic; flush overrides everything
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = is_md ? CALC : DONE;
      CALC: if (cnt == CW'(1)) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  // operand latch, iteration datapath and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c     <= '0;
      hi    <= '0;
      lo    <= '0;
      md    <= '0;
      ar    <= '0;
      cnt   <= '0;
      opr   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      opr <= alu_op;
      if (is_md) begin
        cnt   <= CW'(WIDTH);
        hi    <= '0;
        lo    <= is_mul ? mb : ma;
        md    <= is_mul ? ma : mb;
        ar    <= A;
        neg_q <= sa ^ sb;
        neg_r <= sa;
        dz    <= (B == '0);
      end else begin
        c <= alu_res;
      end
    end else if (state == CALC) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) c <= md_res;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: vector table, backpressure,
// flush and async reset sequences.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  alu_op = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] C;

  int checks = 0;
  int errors = 0;

  alu_mdu #(.WIDTH(32), .OP_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .C(C)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t v[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present op, accept it, return cycles until out_valid
  task automatic issue(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    alu_op   = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A        = $urandom;
    B        = $urandom;
    alu_op   = 5'(3);
    lat      = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    logic        seen;

    v.push_back('{"add",   5'd0,  32'hFFFF_FFFE, 32'd3, 32'h0000_0001, 1});
    v.push_back('{"sub",   5'd1,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFB, 1});
    v.push_back('{"and",   5'd2,  32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 1});
    v.push_back('{"or",    5'd3,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1});
    v.push_back('{"xor",   5'd4,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFD, 1});
    v.push_back('{"nor",   5'd5,  32'hFFFF_FFFE, 32'd3, 32'h0000_0000, 1});
    v.push_back('{"sll",   5'd6,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFF0, 1});
    v.push_back('{"srl",   5'd7,  32'hFFFF_FFFE, 32'd3, 32'h1FFF_FFFF, 1});
    v.push_back('{"sra",   5'd8,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1});
    v.push_back('{"slt",   5'd9,  32'hFFFF_FFFE, 32'd3, 32'h0000_0001, 1});
    v.push_back('{"sltu",  5'd10, 32'hFFFF_FFFE, 32'd3, 32'h0000_0000, 1});
    v.push_back('{"sll32", 5'd6,  32'h0000_0001, 32'h25, 32'h0000_0020, 1});
    v.push_back('{"badop", 5'd31, 32'hFFFF_FFFE, 32'd3, 32'h0000_0001, 1});
    v.push_back('{"mul",   5'd11, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33});
    v.push_back('{"mulh",  5'd12, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33});
    v.push_back('{"mulhu", 5'd13, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 33});
    v.push_back('{"mulh2", 5'd12, 32'h8000_0000, 32'h8000_0000,
                  32'h4000_0000, 33});
    v.push_back('{"div",   5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33});
    v.push_back('{"mod",   5'd15, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33});
    v.push_back('{"divu",  5'd16, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33});
    v.push_back('{"modu",  5'd17, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 33});
    v.push_back('{"divovf", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF,
                  32'h8000_0000, 33});
    v.push_back('{"modovf", 5'd15, 32'h8000_0000, 32'hFFFF_FFFF,
                  32'h0000_0000, 33});
    v.push_back('{"divu0", 5'd16, 32'd5, 32'd0, 32'hFFFF_FFFF, 33});
    v.push_back('{"modu0", 5'd17, 32'd5, 32'd0, 32'h0000_0005, 33});
    v.push_back('{"div0",  5'd14, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 33});
    v.push_back('{"mod0",  5'd15, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 33});
    v.push_back('{"mod7n", 5'd15, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 33});

    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c", C, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    out_ready = 1'b1;
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, lat);
      chk({v[i].name, "_lat"}, 32'(lat), 32'(v[i].lat));
      chk(v[i].name, C, v[i].exp);
      tick();
      chk({v[i].name, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    end

    // backpressure: hold result for 10 cycles, offer a new op meanwhile
    out_ready = 1'b0;
    issue(5'd14, 32'd100, 32'd7, lat);
    chk("bp_lat", 32'(lat), 32'd33);
    chk("bp_c", C, 32'd14);
    held     = C;
    alu_op   = 5'd0;
    A        = 32'd1;
    B        = 32'd1;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_hold_c", C, held);
      chk("bp_hold_vr", {30'd0, in_ready, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    chk("bp_release", {30'd0, in_ready, out_valid}, 32'd2);
    tick();
    chk("bp_no_accept", {31'd0, out_valid}, 32'd0);
    chk("bp_c_kept", C, held);

    // flush at CALC cycle 10 with a competing in_valid
    issue_flush: begin
      alu_op   = 5'd14;
      A        = 32'd1000;
      B        = 32'd3;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      chk("fl_calc", {30'd0, in_ready, out_valid}, 32'd0);
      flush    = 1'b1;
      in_valid = 1'b1;
      alu_op   = 5'd0;
      A        = 32'd5;
      B        = 32'd6;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_idle", {30'd0, in_ready, out_valid}, 32'd2);
      chk("fl_c_kept", C, held);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (out_valid) seen = 1'b1;
      end
      chk("fl_no_result", {31'd0, seen}, 32'd0);
      chk("fl_c_final", C, held);
    end

    // async reset in the middle of a cycle during CALC
    alu_op   = 5'd11;
    A        = 32'd9;
    B        = 32'd9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_vr", {30'd0, in_ready, out_valid}, 32'd2);
    chk("rst_async_c", C, 32'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("rst_no_result", {31'd0, seen}, 32'd0);

    // async reset while a result is waiting in DONE
    out_ready = 1'b0;
    issue(5'd0, 32'd2, 32'd3, lat);
    chk("done_c", C, 32'd5);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_done_vr", {30'd0, in_ready, out_valid}, 32'd2);
    chk("rst_done_c", C, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, multi-cycle successor to the single-cycle integer ALU in the EX stage.
- Executes all existing ALU ops plus LA32R multiply/divide (mul.w, mulh.w, mulh.wu, div.w, mod.w, div.wu, mod.wu).
- Uses a valid/ready handshake on input and output so the pipeline can stall on long operations.
- Multiply and divide are iterative, one bit per cycle; all other ops complete in one cycle.

Parameters:
- WIDTH, 32: operand/result width; must be a power of two, at least 8.
- OP_W, 5: width of alu_op.
- SH_W, $clog2(WIDTH): shift-amount width taken from B.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous abort of any operation in flight.
- in_valid  input  1  A/B/alu_op valid.
- in_ready  output  1  unit can accept an operation.
- alu_op  input  OP_W  operation code (see Behaviour).
- A  input  WIDTH  operand 1.
- B  input  WIDTH  operand 2.
- out_valid  output  1  C holds a completed result.
- out_ready  input  1  consumer takes C.
- C  output  WIDTH  registered result.

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=1; out_valid=0; C=0; iteration counter=0.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLL, 7 SRL, 8 SRA: shift by B[SH_W-1:0].
  - 9 SLT (signed), 10 SLTU (unsigned): result zero-extended to WIDTH.
  - 11 MUL: low WIDTH bits of product. 12 MULH: signed high half. 13 MULHU: unsigned high half.
  - 14 DIV, 15 MOD: signed. 16 DIVU, 17 MODU: unsigned.
  - Any other code: ADD.
- Signed MOD result takes the sign of A; signed DIV truncates toward zero.
- Divide by zero (all div/mod ops): quotient all ones; remainder = A.
- Signed overflow, MIN / -1: quotient = MIN; remainder = 0.
- Operands are latched at acceptance; later changes on A/B/alu_op have no effect.
- State machine:
  - IDLE: in_ready=1. Accept on in_valid&&in_ready.
    - Single-cycle op: go to DONE with C loaded.
    - Mul/div op: go to CALC with counter=WIDTH.
  - CALC: in_ready=0. One shift-add (multiply) or restoring-subtract (divide) step per cycle on magnitudes. Counter decrements each cycle. When counter reaches 1, apply sign fix-up and special cases, load C, go to DONE.
  - DONE: out_valid=1, in_ready=0. C is held stable until out_ready=1. On out_valid&&out_ready, go to IDLE (out_valid=0 next cycle).
- Latency, acceptance edge to out_valid=1:
  - Single-cycle ops: 1 cycle.
  - Mul/div ops: WIDTH+1 cycles (33 at WIDTH=32).
  - Throughput: one op per 2 cycles minimum; no back-to-back acceptance in DONE.
- flush=1 (synchronous, highest priority after rst):
  - Next state is IDLE; out_valid=0; C keeps its old value.
  - A concurrent in_valid is ignored.
  - Flush while IDLE is a no-op.
- out_ready while out_valid=0 is ignored.
- out_valid never deasserts without out_ready or flush.
- Reset asserted mid-CALC or in DONE: immediate IDLE; result lost.

Test Plan:
- Basic ops, WIDTH=32: A=0xFFFF_FFFE, B=0x0000_0003.
  - ADD -> 0x0000_0001. SRA -> 0xFFFF_FFFF. SRL -> 0x1FFF_FFFF.
  - SLT -> 1. SLTU -> 0. NOR -> 0x0000_0000.
  - Each result out_valid exactly 1 cycle after accept.
- Multiply: A=0xFFFF_FFFF, B=0x0000_0002.
  - MUL -> 0xFFFF_FFFE. MULH -> 0xFFFF_FFFF. MULHU -> 0x0000_0001.
  - out_valid asserts 33 cycles after accept.
- Divide: A=-7 (0xFFFF_FFF9), B=2.
  - DIV -> 0xFFFF_FFFD. MOD -> 0xFFFF_FFFF. DIVU -> 0x7FFF_FFFC. MODU -> 1.
- Boundaries:
  - DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; MOD of the same -> 0.
  - DIVU 5/0 -> 0xFFFF_FFFF; MODU 5/0 -> 5.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - C and out_valid stay stable; in_ready stays 0; a new in_valid is not accepted.
  - Release out_ready -> IDLE next cycle.
- Flush/reset: flush at CALC cycle 10 of a DIV, with in_valid=1 in the same cycle.
  - Next cycle IDLE, in_ready=1, out_valid=0; no result ever emitted; the concurrent op is not accepted.
  - Repeat with rst pulse mid-cycle: outputs clear asynchronously.
